// File: rtl/pattern_sequencer.sv
// Pattern playback: 4-entry segment table, tick-enabled beat pointer, 1-cycle RAM fetch -> note/gate.
// Beat decided at T, mem_rd at T+1, note/gate/beat_strobe at T+3; no backpressure (RAM always ready).
module pattern_sequencer #(
  parameter logic [31:0] MAIN_CLK_SPEED = 32'd12_288_000,
  parameter logic [31:0] BEAT_RATE      = 32'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       restart,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [9:0] cfg_start,
  input  logic [9:0] cfg_end,
  input  logic [3:0] cfg_reps,
  input  logic [1:0] seg_last,
  output logic [9:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  output logic [7:0] note,
  output logic       gate,
  output logic       beat_strobe,
  output logic [1:0] cur_seg
);
  localparam logic [31:0] PERIOD    = MAIN_CLK_SPEED / BEAT_RATE;
  localparam logic [31:0] TICK_LAST = PERIOD - 32'd1;
  localparam logic [31:0] GATE_OFF  = (PERIOD >> 1) - 32'd1;

  typedef enum logic [1:0] {STOPPED, RUNNING, PAUSED} state_t;

  state_t      state_q, state_d;
  logic [31:0] tick_q, tick_d;
  logic [9:0]  pos_q, pos_d;
  logic [1:0]  seg_q, seg_d;
  logic [3:0]  rep_q, rep_d;
  logic        rd_q, rd_d;
  logic        pend_q, pend_d;
  logic [7:0]  note_q, note_d;
  logic        gate_q, gate_d;
  logic        strobe_q, strobe_d;

  logic [9:0]  start_q [4];
  logic [9:0]  end_q   [4];
  logic [3:0]  reps_q  [4];

  logic [9:0]  nxt_pos;
  logic [1:0]  nxt_seg;
  logic [3:0]  nxt_rep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        start_q[i] <= 10'd0;
        end_q[i]   <= 10'd0;
        reps_q[i]  <= 4'd0;
      end
      end_q[0] <= 10'd1023;
    end else if (cfg_we) begin
      start_q[cfg_sel] <= cfg_start;
      end_q[cfg_sel]   <= cfg_end;
      reps_q[cfg_sel]  <= cfg_reps;
    end
  end

  // seg_last may have shrunk below the current segment: treat that as "last".
  always_comb begin
    nxt_pos = pos_q + 10'd1;
    nxt_seg = seg_q;
    nxt_rep = rep_q;
    if (pos_q == end_q[seg_q]) begin
      if (rep_q < reps_q[seg_q]) begin
        nxt_rep = rep_q + 4'd1;
        nxt_pos = start_q[seg_q];
      end else begin
        nxt_rep = 4'd0;
        nxt_seg = (seg_q >= seg_last) ? 2'd0 : seg_q + 2'd1;
        nxt_pos = start_q[nxt_seg];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    pos_d    = pos_q;
    seg_d    = seg_q;
    rep_d    = rep_q;
    rd_d     = 1'b0;
    pend_d   = rd_q;
    note_d   = note_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;

    if (pend_q) begin
      note_d   = mem_data;
      gate_d   = (mem_data != 8'd0) && (state_q == RUNNING) && play;
      strobe_d = 1'b1;
      pos_d    = nxt_pos;
      seg_d    = nxt_seg;
      rep_d    = nxt_rep;
    end

    case (state_q)
      STOPPED: begin
        if (play) begin
          state_d = RUNNING;
          tick_d  = TICK_LAST;
        end
      end
      RUNNING: begin
        if (tick_q == TICK_LAST) begin
          tick_d = 32'd0;
          rd_d   = 1'b1;
        end else begin
          tick_d = tick_q + 32'd1;
        end
        if (tick_q == GATE_OFF) gate_d = 1'b0;
        if (!play) begin
          state_d = PAUSED;
          gate_d  = 1'b0;
        end
      end
      PAUSED: begin
        if (play) state_d = RUNNING;
      end
      default: state_d = STOPPED;
    endcase

    // Restart wins over everything, including a fetch already in flight.
    if (restart) begin
      state_d  = STOPPED;
      tick_d   = 32'd0;
      pos_d    = start_q[0];
      seg_d    = 2'd0;
      rep_d    = 4'd0;
      rd_d     = 1'b0;
      pend_d   = 1'b0;
      note_d   = 8'd0;
      gate_d   = 1'b0;
      strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STOPPED;
      tick_q   <= 32'd0;
      pos_q    <= 10'd0;
      seg_q    <= 2'd0;
      rep_q    <= 4'd0;
      rd_q     <= 1'b0;
      pend_q   <= 1'b0;
      note_q   <= 8'd0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      pos_q    <= pos_d;
      seg_q    <= seg_d;
      rep_q    <= rep_d;
      rd_q     <= rd_d;
      pend_q   <= pend_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
    end
  end

  assign mem_addr    = pos_q;
  assign mem_rd      = rd_q;
  assign note        = note_q;
  assign gate        = gate_q;
  assign beat_strobe = strobe_q;
  assign cur_seg     = seg_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with PERIOD = 8; RAM model holds k+1 at address k.
module tb_pattern_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       restart;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [9:0] cfg_start;
  logic [9:0] cfg_end;
  logic [3:0] cfg_reps;
  logic [1:0] seg_last;
  logic [9:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic [7:0] note;
  logic       gate;
  logic       beat_strobe;
  logic [1:0] cur_seg;

  logic [7:0] ram [1024];
  int checks = 0;
  int errors = 0;

  pattern_sequencer #(.MAIN_CLK_SPEED(32'd16), .BEAT_RATE(32'd2)) dut (
    .clk(clk), .reset(reset), .play(play), .restart(restart),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .cfg_reps(cfg_reps), .seg_last(seg_last), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .note(note), .gate(gate), .beat_strobe(beat_strobe),
    .cur_seg(cur_seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [9:0] s, input logic [9:0] e,
                     input logic [3:0] r);
    cfg_we = 1'b1; cfg_sel = sel; cfg_start = s; cfg_end = e; cfg_reps = r;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_mem_rd(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_rd && n < 40);
    chk(tag, 32'(mem_rd), 32'd1);
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!beat_strobe && n < 40);
    chk(tag, 32'(beat_strobe), 32'd1);
  endtask

  initial begin
    logic [7:0] notes1 [3];
    logic [7:0] notes2 [6];
    logic [1:0] segs2  [6];
    logic [9:0] wrap   [5];
    notes1 = '{8'd5, 8'd3, 8'd4};
    notes2 = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd11, 8'd1};
    segs2  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    wrap   = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd1022};
    for (int k = 0; k < 1024; k++) ram[k] = 8'(k + 1);

    reset = 1'b1; play = 1'b0; restart = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0;
    cfg_start = 10'd0; cfg_end = 10'd0; cfg_reps = 4'd0; seg_last = 2'd0;
    cyc(2);
    chk("rst note", 32'(note), 32'd0);
    chk("rst gate", 32'(gate), 32'd0);
    chk("rst mem_rd", 32'(mem_rd), 32'd0);
    chk("rst strobe", 32'(beat_strobe), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    chk("rst seg", 32'(cur_seg), 32'd0);
    reset = 1'b0;
    cyc(1);

    // Basic playback, segment {2,4,0}
    cfg(2'd0, 10'd2, 10'd4, 4'd0);
    do_restart();
    chk("basic start addr", 32'(mem_addr), 32'd2);
    play = 1'b1;
    cyc(1); chk("basic no rd C1", 32'(mem_rd), 32'd0);
    cyc(1); chk("basic rd C2", 32'(mem_rd), 32'd1);
    chk("basic rd addr", 32'(mem_addr), 32'd2);
    cyc(1); chk("basic rd pulse", 32'(mem_rd), 32'd0);
    chk("basic no strobe C3", 32'(beat_strobe), 32'd0);
    cyc(1); chk("basic strobe C4", 32'(beat_strobe), 32'd1);
    chk("basic note 3", 32'(note), 32'd3);
    chk("basic gate C4", 32'(gate), 32'd1);
    chk("basic addr after", 32'(mem_addr), 32'd3);
    cyc(1); chk("basic gate C5", 32'(gate), 32'd1);
    chk("basic strobe pulse", 32'(beat_strobe), 32'd0);
    cyc(1); chk("basic gate C6", 32'(gate), 32'd0);
    cyc(4); chk("basic rd C10", 32'(mem_rd), 32'd1);
    cyc(2); chk("basic note 4", 32'(note), 32'd4);
    chk("basic strobe C12", 32'(beat_strobe), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(6); chk("basic rd interval", 32'(mem_rd), 32'd1);
      cyc(2); chk("basic note seq", 32'(note), 32'(notes1[i]));
    end
    play = 1'b0;
    do_restart();

    // Repeats and two-segment arrangement
    cfg(2'd0, 10'd0, 10'd1, 4'd1);
    cfg(2'd1, 10'd10, 10'd10, 4'd0);
    seg_last = 2'd1;
    do_restart();
    play = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_strobe("arr strobe timeout");
      chk("arr note", 32'(note), 32'(notes2[i]));
      chk("arr cur_seg", 32'(cur_seg), 32'(segs2[i]));
    end
    play = 1'b0;
    do_restart();

    // Rest beat: note 0 keeps gate low; next beat gates for 2 cycles
    ram[3] = 8'd0;
    seg_last = 2'd0;
    cfg(2'd0, 10'd3, 10'd4, 4'd0);
    do_restart();
    play = 1'b1;
    wait_strobe("rest strobe timeout");
    chk("rest note", 32'(note), 32'd0);
    chk("rest gate", 32'(gate), 32'd0);
    wait_strobe("rest strobe2 timeout");
    chk("rest note5", 32'(note), 32'd5);
    chk("rest gate c0", 32'(gate), 32'd1);
    cyc(1); chk("rest gate c1", 32'(gate), 32'd1);
    cyc(1); chk("rest gate c2", 32'(gate), 32'd0);
    ram[3] = 8'd4;
    play = 1'b0;
    do_restart();

    // Pause 3 cycles after mem_rd, hold 20 cycles, resume
    cfg(2'd0, 10'd2, 10'd4, 4'd0);
    do_restart();
    play = 1'b1;
    wait_strobe("pause strobe timeout");
    chk("pause pre note", 32'(note), 32'd3);
    cyc(1);
    play = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("pause gate", 32'(gate), 32'd0);
      chk("pause addr", 32'(mem_addr), 32'd3);
      chk("pause rd", 32'(mem_rd), 32'd0);
    end
    play = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1); chk("resume no rd", 32'(mem_rd), 32'd0);
    end
    cyc(1); chk("resume rd R5", 32'(mem_rd), 32'd1);
    chk("resume rd addr", 32'(mem_addr), 32'd3);
    cyc(2); chk("resume note", 32'(note), 32'd4);
    chk("resume gate", 32'(gate), 32'd1);

    // Restart while a fetch is in flight
    wait_mem_rd("rst-fetch rd timeout");
    chk("rst-fetch rd addr", 32'(mem_addr), 32'd4);
    do_restart();
    chk("rst-fetch note", 32'(note), 32'd0);
    chk("rst-fetch gate", 32'(gate), 32'd0);
    chk("rst-fetch addr", 32'(mem_addr), 32'd2);
    chk("rst-fetch rd", 32'(mem_rd), 32'd0);
    cyc(1); chk("rst-fetch discard", 32'(beat_strobe), 32'd0);
    chk("rst-fetch note2", 32'(note), 32'd0);
    cyc(1); chk("rst-fetch relaunch rd", 32'(mem_rd), 32'd1);
    chk("rst-fetch relaunch addr", 32'(mem_addr), 32'd2);
    play = 1'b0;
    do_restart();

    // Segment wrapping through 1023 -> 0
    cfg(2'd0, 10'd1022, 10'd1, 4'd0);
    do_restart();
    play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_mem_rd("wrap rd timeout");
      chk("wrap addr", 32'(mem_addr), 32'(wrap[i]));
    end
    cyc(2);
    chk("wrap note", 32'(note), 32'd255);

    // Asynchronous reset between edges
    #1 reset = 1'b1;
    #1;
    chk("async note", 32'(note), 32'd0);
    chk("async gate", 32'(gate), 32'd0);
    chk("async addr", 32'(mem_addr), 32'd0);
    chk("async strobe", 32'(beat_strobe), 32'd0);
    chk("async seg", 32'(cur_seg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_mem_rd("post-rst rd timeout");
    chk("post-rst addr0", 32'(mem_addr), 32'd0);
    wait_mem_rd("post-rst rd2 timeout");
    chk("post-rst addr1", 32'(mem_addr), 32'd1);
    cyc(2);
    chk("post-rst note", 32'(note), 32'd2);
    chk("post-rst next addr", 32'(mem_addr), 32'd2);
    chk("post-rst seg", 32'(cur_seg), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Playback controller for the synth's pattern memory. It holds a 4-entry segment table (start address, end address, repeat count) and steps a beat pointer through each segment at a tempo derived from the main clock. It fetches one note per beat from a 1-cycle-latency pattern RAM and drives note/gate to the voice. It uses a synchronous tick enable, not a derived clock, and adds play/pause/restart control and multi-segment arrangement.

## Interface
- MAIN_CLK_SPEED, 32'd12_288_000, main clock frequency in Hz
- BEAT_RATE, 32'd4, beats per second; PERIOD = MAIN_CLK_SPEED/BEAT_RATE (must be ≥ 4 and even)
- clk  in  1  main clock
- reset  in  1  asynchronous, active-high
- play  in  1  level; 1 = run, 0 = pause
- restart  in  1  one-cycle pulse; return to segment 0 start
- cfg_we  in  1  segment-table write strobe
- cfg_sel  in  2  table entry to write
- cfg_start, cfg_end  in  10 each  segment start/end address
- cfg_reps  in  4  extra passes of the segment (0 = play once)
- seg_last  in  2  index of last active segment (active = 0..seg_last)
- mem_addr  out  10  pattern RAM address (registered, equals beat pointer)
- mem_rd  out  1  read strobe, one cycle per beat
- mem_data  in  8  RAM data, valid the cycle after mem_rd
- note  out  8  current note code; 0 = rest
- gate  out  1  note active
- beat_strobe  out  1  one-cycle pulse when note updates
- cur_seg  out  2  segment being played

## Operation
- States: STOPPED, RUNNING, PAUSED.
- Reset:
  - Enters STOPPED. pos=0, seg=0, rep=0, tick=0.
  - All outputs 0.
  - Table entry 0 = {start 0, end 1023, reps 0}; entries 1–3 = all zeros.
- Transitions:
  - STOPPED & play → RUNNING. tick is loaded with PERIOD-1, so the first beat fires on the next cycle.
  - RUNNING & !play → PAUSED. tick, pos, seg and rep hold; gate forced 0.
  - PAUSED & play → RUNNING. tick resumes from its held value.
  - restart, in any state → STOPPED. pos=start[0], seg=0, rep=0, tick=0, gate=0, note=0. restart has priority over play and over a fetch in flight; the fetch is discarded.
- Tick: in RUNNING, tick increments each cycle. At tick==PERIOD-1 a beat event occurs: tick←0, mem_rd←1.
- Fetch: mem_data is captured the cycle after mem_rd is high. On capture:
  - note←mem_data
  - gate←(mem_data≠0)
  - beat_strobe←1
  - pos←next
- Next-pointer rule:
  - pos≠end[seg]: pos+1, modulo 1024. start>end is legal and wraps through 1023→0.
  - pos==end[seg], rep<reps[seg]: rep+1, pos←start[seg].
  - pos==end[seg], rep==reps[seg]: rep←0, seg←(seg==seg_last)?0:seg+1, pos←start[new seg].
  - cur_seg mirrors seg.
- Gate release: gate←0 when tick reaches PERIOD/2 − 1 in RUNNING.
- Fetch during pause: if play drops while a fetch is in flight, the fetch completes (note and pos update, beat_strobe pulses) but gate stays 0.
- Config writes are accepted in any state and commit at the clock edge.
  - Start and reps values are used at the next segment load or loop.
  - A change to end[seg] of the current segment affects the very next comparison.
  - On a simultaneous restart and write to entry 0, restart uses the old start[0].
- If seg_last changes below the current seg, the current segment finishes, then seg wraps to 0.

## Timing
- Beat event decided in cycle T. mem_rd high and mem_addr=pos in T+1. mem_data sampled at end of T+2. note/gate/beat_strobe/new mem_addr visible in T+3.
- Beat-to-beat interval: exactly PERIOD cycles while RUNNING.
- With gate=1, gate stays high PERIOD/2 − 2 cycles.
- mem_rd and beat_strobe are single-cycle pulses and never overlap for the same beat.

## Test plan
All scenarios use MAIN_CLK_SPEED=16, BEAT_RATE=2 (PERIOD=8). RAM content: addr k holds k+1.
- Basic playback: table 0={2,4,0}, seg_last=0, play=1.
  - mem_rd pulses every 8 cycles.
  - note sequence is 3,4,5,3,4,…; first mem_rd occurs 2 cycles after play rises.
- Repeats and arrangement: seg0={0,1,1}, seg1={10,10,0}, seg_last=1.
  - Notes 1,2,1,2,11,1,…
  - cur_seg changes 0→1→0 in the beat_strobe cycles.
- Rest and gate: RAM addr 3 = 0, segment {3,4,0}.
  - The note-0 beat has gate=0.
  - On the following beat, gate is high for exactly 2 cycles.
- Pause and resume: drop play 3 cycles after a beat for 20 cycles.
  - gate=0 and mem_addr holds during the pause.
  - The next mem_rd comes 5 RUNNING cycles after resume.
- Restart mid-fetch and wrap: pulse restart in the cycle mem_rd is high.
  - note stays 0, state is STOPPED, mem_addr=start[0].
  - Separately, segment {1022,1,0} yields addresses 1022,1023,0,1.
- Reset mid-run: assert reset between clock edges.
  - All outputs go to 0 immediately (asynchronously).
  - Table entry 0 reads back as {0,1023,0}.
